// File: rtl/mem_stage.sv
//------------------------------------------------------------------------------
// Module   : mem_stage
// Purpose  : Pipeline MEM stage. Non-memory ops pass straight to the MEM/WB
//            registers in one cycle. Loads and stores issue a single request
//            to a handshaked data SRAM. Upstream stages are stalled (Freeze)
//            until the SRAM acknowledges, and bubbles go downstream meanwhile.
// Ports    : clk, rst (async, active-low)
//            WB_En, Mem_R_En, Mem_W_En, Dest, ALU_Res, Val_Rm  - from EX
//            Freeze                                             - stall to EX
//            WB_En_Out, Mem_R_En_Out, Dest_Out, ALU_Res_Out,
//            Mem_Data_Out, Mem_Err                              - MEM/WB regs
//            Sram_Req, Sram_We, Sram_Addr, Sram_WData           - SRAM request
//            Sram_RData, Sram_Ack                               - SRAM response
// Options  : MEM_TIMEOUT_EN - abort an access after TIMEOUT_CYCLES ACCESS
//            cycles without Ack, returning 32'hDEADBEEF and pulsing Mem_Err.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_stage #(
  parameter int unsigned BASE_ADDR      = 1024,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_En,
  input  logic              Mem_R_En,
  input  logic              Mem_W_En,
  input  logic [3:0]        Dest,
  input  logic [31:0]       ALU_Res,
  input  logic [31:0]       Val_Rm,
  output logic              Freeze,
  output logic              WB_En_Out,
  output logic              Mem_R_En_Out,
  output logic [3:0]        Dest_Out,
  output logic [31:0]       ALU_Res_Out,
  output logic [31:0]       Mem_Data_Out,
  output logic              Mem_Err,
  output logic              Sram_Req,
  output logic              Sram_We,
  output logic [ADDR_W-1:0] Sram_Addr,
  output logic [31:0]       Sram_WData,
  input  logic [31:0]       Sram_RData,
  input  logic              Sram_Ack
);

  localparam logic [0:0]  S_IDLE   = 1'b0;
  localparam logic [0:0]  S_ACCESS = 1'b1;
  localparam logic [31:0] C_BASE   = 32'(BASE_ADDR);
  localparam logic [31:0] C_ABORT  = 32'hDEAD_BEEF;

  logic [0:0]        r_state;
  logic              r_sram_req;
  logic              r_sram_we;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [31:0]       r_sram_wdata;
  logic              r_wb_en_out;
  logic              r_mem_r_en_out;
  logic [3:0]        r_dest_out;
  logic [31:0]       r_alu_res_out;
  logic [31:0]       r_mem_data_out;

  logic              w_mem_req;
  logic              w_start;
  logic              w_access;
  logic              w_ack;
  logic              w_timeout;
  logic              w_freeze;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_mem_data;

  if (TIMEOUT_CYCLES == 0) begin : g_timeout_param_check
    $error("mem_stage: TIMEOUT_CYCLES must be at least 1");
  end

  assign w_mem_req = Mem_R_En | Mem_W_En;
  assign w_access  = (r_state == S_ACCESS);
  assign w_start   = (r_state == S_IDLE) & w_mem_req;
  assign w_ack     = w_access & Sram_Ack;

  // Addresses below the base wrap naturally through the unsigned subtract;
  // the byte offset bits are dropped before truncating to the word width.
  assign w_addr = ADDR_W'((ALU_Res - C_BASE) >> 2);

  // Freeze drops combinationally in the cycle the access completes so the
  // upstream stage and the MEM/WB registers advance on the same edge.
  assign w_freeze = w_start | (w_access & ~Sram_Ack & ~w_timeout);

  // Completion data: read data on an acked load, zero on a store or a
  // non-memory op, and a recognisable marker on an aborted access.
  always_comb begin
    w_mem_data = 32'h0;
    if (w_ack) begin
      w_mem_data = r_sram_we ? 32'h0 : Sram_RData;
    end else if (w_timeout) begin
      w_mem_data = C_ABORT;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_err;

  // The counter holds the number of ACCESS cycles already spent; the abort
  // fires in the TIMEOUT_CYCLES-th ACCESS cycle if Ack is still low.
  assign w_timeout = w_access & ~Sram_Ack & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_mem_err <= w_timeout;
      if (w_access) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign Mem_Err = r_mem_err;
`else
  assign w_timeout = 1'b0;
  assign Mem_Err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_sram_req     <= 1'b0;
      r_sram_we      <= 1'b0;
      r_sram_addr    <= '0;
      r_sram_wdata   <= 32'h0;
      r_wb_en_out    <= 1'b0;
      r_mem_r_en_out <= 1'b0;
      r_dest_out     <= 4'h0;
      r_alu_res_out  <= 32'h0;
      r_mem_data_out <= 32'h0;
    end else begin
      if (r_state == S_IDLE) begin
        // Ack arriving here is stale and deliberately ignored.
        if (w_mem_req) begin
          r_sram_req   <= 1'b1;
          r_sram_we    <= Mem_W_En;
          r_sram_addr  <= w_addr;
          r_sram_wdata <= Val_Rm;
          r_state      <= S_ACCESS;
        end
      end else begin
        if (Sram_Ack || w_timeout) begin
          r_sram_req <= 1'b0;
          r_state    <= S_IDLE;
        end
      end

      if (w_freeze) begin
        r_wb_en_out    <= 1'b0;
        r_mem_r_en_out <= 1'b0;
      end else begin
        r_wb_en_out    <= WB_En;
        // A combined read/write request executes as a store only.
        r_mem_r_en_out <= Mem_R_En & ~Mem_W_En;
        r_dest_out     <= Dest;
        r_alu_res_out  <= ALU_Res;
        r_mem_data_out <= w_mem_data;
      end
    end
  end

  assign Freeze       = w_freeze;
  assign WB_En_Out    = r_wb_en_out;
  assign Mem_R_En_Out = r_mem_r_en_out;
  assign Dest_Out     = r_dest_out;
  assign ALU_Res_Out  = r_alu_res_out;
  assign Mem_Data_Out = r_mem_data_out;
  assign Sram_Req     = r_sram_req;
  assign Sram_We      = r_sram_we;
  assign Sram_Addr    = r_sram_addr;
  assign Sram_WData   = r_sram_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage: directed vector table,
//            randomized ops against a transaction-level model with a word
//            memory, reset-during-access and (optionally) timeout sequences.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned TO_CYC = 4;

  logic              clk;
  logic              rst;
  logic              WB_En, Mem_R_En, Mem_W_En;
  logic [3:0]        Dest;
  logic [31:0]       ALU_Res, Val_Rm;
  logic              Freeze;
  logic              WB_En_Out, Mem_R_En_Out;
  logic [3:0]        Dest_Out;
  logic [31:0]       ALU_Res_Out, Mem_Data_Out;
  logic              Mem_Err;
  logic              Sram_Req, Sram_We;
  logic [ADDR_W-1:0] Sram_Addr;
  logic [31:0]       Sram_WData, Sram_RData;
  logic              Sram_Ack;

  mem_stage #(
    .BASE_ADDR      (1024),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .WB_En        (WB_En),
    .Mem_R_En     (Mem_R_En),
    .Mem_W_En     (Mem_W_En),
    .Dest         (Dest),
    .ALU_Res      (ALU_Res),
    .Val_Rm       (Val_Rm),
    .Freeze       (Freeze),
    .WB_En_Out    (WB_En_Out),
    .Mem_R_En_Out (Mem_R_En_Out),
    .Dest_Out     (Dest_Out),
    .ALU_Res_Out  (ALU_Res_Out),
    .Mem_Data_Out (Mem_Data_Out),
    .Mem_Err      (Mem_Err),
    .Sram_Req     (Sram_Req),
    .Sram_We      (Sram_We),
    .Sram_Addr    (Sram_Addr),
    .Sram_WData   (Sram_WData),
    .Sram_RData   (Sram_RData),
    .Sram_Ack     (Sram_Ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wb, rd, wr;
    logic [3:0]  dest;
    logic [31:0] alu, val;
    int          delay;
    logic [31:0] rdata;
    logic [15:0] e_addr;
    logic [31:0] e_mdata;
    logic        e_rout;
    int          e_fz;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;

  // Last values the MEM/WB registers are expected to hold.
  logic [3:0]  m_dest  = 4'h0;
  logic [31:0] m_alu   = 32'h0;
  logic [31:0] m_mdata = 32'h0;

  logic [31:0] model_mem [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wb, input logic rd, input logic wr,
                       input logic [3:0] dest, input logic [31:0] alu, input logic [31:0] val);
    WB_En = wb; Mem_R_En = rd; Mem_W_En = wr; Dest = dest; ALU_Res = alu; Val_Rm = val;
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_req"},   Sram_Req, 0);
    check({tag, "_we"},    Sram_We, 0);
    check({tag, "_addr"},  32'(Sram_Addr), 0);
    check({tag, "_wdata"}, Sram_WData, 0);
    check({tag, "_wbo"},   WB_En_Out, 0);
    check({tag, "_mro"},   Mem_R_En_Out, 0);
    check({tag, "_dest"},  32'(Dest_Out), 0);
    check({tag, "_alu"},   ALU_Res_Out, 0);
    check({tag, "_mdata"}, Mem_Data_Out, 0);
    check({tag, "_err"},   Mem_Err, 0);
  endtask

  // Applies one op at posedge+1 and follows it cycle by cycle to completion,
  // playing the SRAM with the given Ack delay and read data.
  task automatic do_op(input vec_t v);
    int fz = 0;
    drive(v.wb, v.rd, v.wr, v.dest, v.alu, v.val);
    if (!(v.rd || v.wr)) begin
      @(negedge clk);
      if (Freeze) fz++;
      check("nonmem_freeze", Freeze, 0);
      tick();
    end else begin
      @(negedge clk);
      if (Freeze) fz++;
      check("req_freeze", Freeze, 1);
      tick();
      check("sram_req", Sram_Req, 1);
      check("sram_we", Sram_We, v.wr);
      check("sram_addr", 32'(Sram_Addr), 32'(v.e_addr));
      check("sram_wdata", Sram_WData, v.val);
      check("bubble_wb", WB_En_Out, 0);
      check("bubble_mr", Mem_R_En_Out, 0);
      check("hold_dest", 32'(Dest_Out), 32'(m_dest));
      check("hold_alu", ALU_Res_Out, m_alu);
      check("hold_mdata", Mem_Data_Out, m_mdata);
      for (int k = 0; k < v.delay; k++) begin
        Sram_Ack = 1'b0;
        Sram_RData = $urandom;
        @(negedge clk);
        if (Freeze) fz++;
        check("wait_freeze", Freeze, 1);
        check("wait_req", Sram_Req, 1);
        check("wait_addr", 32'(Sram_Addr), 32'(v.e_addr));
        tick();
      end
      Sram_Ack = 1'b1;
      Sram_RData = v.rdata;
      @(negedge clk);
      if (Freeze) fz++;
      check("ack_freeze", Freeze, 0);
      tick();
      Sram_Ack = 1'b0;
      Sram_RData = $urandom;
      check("done_req", Sram_Req, 0);
    end
    check("out_wb", WB_En_Out, v.wb);
    check("out_mr", Mem_R_En_Out, v.e_rout);
    check("out_dest", 32'(Dest_Out), 32'(v.dest));
    check("out_alu", ALU_Res_Out, v.alu);
    check("out_mdata", Mem_Data_Out, v.e_mdata);
    check("out_err", Mem_Err, 0);
    check("freeze_cycles", fz, v.e_fz);
    m_dest = v.dest; m_alu = v.alu; m_mdata = v.e_mdata;
  endtask

  vec_t vecs[7];

  initial begin
    vec_t v;
    //            wb    rd    wr    dest   alu            val            dly rdata          addr      mdata          rout  fz
    vecs[0] = '{1'b1, 1'b0, 1'b0, 4'd5,  32'd7,         32'h0,         0, 32'h0,         16'h0000, 32'h0,         1'b0, 0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 4'd2,  32'd1032,      32'h0,         3, 32'h12345678,  16'h0002, 32'h12345678,  1'b1, 4};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 4'd0,  32'd1024,      32'hA5A5A5A5,  0, 32'h0,         16'h0000, 32'h0,         1'b0, 1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 4'd1,  32'd1028,      32'h0BADF00D,  1, 32'h77777777,  16'h0001, 32'h0,         1'b0, 2};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 4'd9,  32'd1020,      32'h0,         2, 32'hCAFEBABE,  16'hFFFF, 32'hCAFEBABE,  1'b1, 3};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 4'd15, 32'd1035,      32'h0,         0, 32'h0F0F0F0F,  16'h0002, 32'h0F0F0F0F,  1'b1, 1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 4'd3,  32'hFFFFFFFF,  32'h0,         0, 32'h0,         16'h0000, 32'h0,         1'b0, 0};

    rst = 1'b0;
    Sram_Ack = 1'b0; Sram_RData = 32'h0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    check_outs_zero("reset");
    check("reset_freeze", Freeze, 0);
    rst = 1'b1;

    // Directed table.
    for (int i = 0; i < 7; i++) do_op(vecs[i]);

    // Stale Ack in IDLE must not disturb anything.
    drive(1, 0, 0, 4'd6, 32'h1111, 0);
    Sram_Ack = 1'b1;
    @(negedge clk);
    check("idle_ack_freeze", Freeze, 0);
    tick();
    Sram_Ack = 1'b0;
    check("idle_ack_req", Sram_Req, 0);
    check("idle_ack_alu", ALU_Res_Out, 32'h1111);
    m_dest = 4'd6; m_alu = 32'h1111; m_mdata = 32'h0;

    // Randomized ops against a word-memory model.
    for (int i = 0; i < 40; i++) begin
      int kind = int'($urandom_range(0, 3));
      logic [15:0] wa;
      v.wb    = 1'($urandom);
      v.rd    = (kind == 1) || (kind == 3);
      v.wr    = (kind == 2) || (kind == 3);
      v.dest  = 4'($urandom);
      v.alu   = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 1023))
                                            : 32'd1024 + 32'($urandom_range(0, 255));
      v.val   = $urandom;
      v.delay = int'($urandom_range(0, 3));
      wa      = 16'((v.alu - 32'd1024) / 4);
      v.e_addr = wa;
      v.rdata = 32'h0; v.e_mdata = 32'h0;
      if (kind == 0) begin
        v.e_fz = 0;
      end else begin
        v.e_fz = 1 + v.delay;
        if (v.wr) begin
          model_mem[int'(wa)] = v.val;
        end else begin
          v.rdata = model_mem.exists(int'(wa)) ? model_mem[int'(wa)]
                                               : {wa, ~wa};
          v.e_mdata = v.rdata;
        end
      end
      v.e_rout = v.rd && !v.wr;
      do_op(v);
    end

`ifndef MEM_TIMEOUT_EN
    // Without the timeout option a slow SRAM is simply waited for.
    v = '{1'b1, 1'b1, 1'b0, 4'd11, 32'd1100, 32'h0, 12, 32'h600DF00D,
          16'd19, 32'h600DF00D, 1'b1, 13};
    do_op(v);
`else
    // Timeout: Ack never comes; stall must end within a bounded window.
    begin
      bit done = 0;
      drive(1, 1, 0, 4'd6, 32'd1036, 0);
      for (int c = 0; c < 20 && !done; c++) begin
        @(negedge clk);
        if (!Freeze && c > 0) done = 1;
        tick();
      end
      check("timeout_done", done, 1);
      drive(0, 0, 0, 0, 0, 0);
      check("timeout_err", Mem_Err, 1);
      check("timeout_mdata", Mem_Data_Out, 32'hDEADBEEF);
      check("timeout_req", Sram_Req, 0);
      check("timeout_wb", WB_En_Out, 1);
      @(negedge clk);
      check("timeout_idle_freeze", Freeze, 0);
      tick();
      check("timeout_err_pulse", Mem_Err, 0);
      check("timeout_idle_req", Sram_Req, 0);
    end
`endif

    // Reset while an access is outstanding.
    do_op('{1'b1, 1'b0, 1'b0, 4'd7, 32'h55, 32'h0, 0, 32'h0, 16'h0, 32'h0, 1'b0, 0});
    drive(1, 1, 0, 4'd4, 32'd1040, 0);
    repeat (3) tick();
    check("pre_reset_req", Sram_Req, 1);
    #2;
    rst = 1'b0;
    #1;
    check_outs_zero("async_reset");
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("async_reset_freeze", Freeze, 0);
    tick();
    check_outs_zero("held_reset");
    rst = 1'b1;
    Sram_Ack = 1'b1;
    Sram_RData = 32'h99999999;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("late_ack_freeze", Freeze, 0);
      tick();
      check_outs_zero("late_ack");
    end
    Sram_Ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
